ahb_rr_arbiter: RTL
===================

// Module: ahb_rr_arbiter
// PURPOSE
//  Two-master AHB-Lite bus arbiter with round-robin fairness, bus locking and a tenure limit.
//  - Sits directly upstream of the master-to-slave address/data mux.
//  - Produces HMASTER, which selects the mux: 0 = no owner (mux drives IDLE), 1 = M1, 2 = M2.
//  - Produces per-master grants and HMASTLOCK.
// PARAMETERS
//  MASTER_BITS  4  width of HMASTER (matches AHB_MASTER_BITS)
//  TRANS_BITS   2  width of HTRANS (IDLE=00 BUSY=01 NONSEQ=10 SEQ=11)
//  MAX_TENURE   8  owner data beats before a pending other master forces rotation (>=1)
// PORTS
//  HCLK        in   1            bus clock, all state on rising edge
//  HRESET      in   1            asynchronous, active-high reset
//  HBUSREQ_M1  in   1            bus request, master 1
//  HBUSREQ_M2  in   1            bus request, master 2
//  HLOCK_M1    in   1            locked-transfer request, master 1
//  HLOCK_M2    in   1            locked-transfer request, master 2
//  HREADY      in   1            global transfer-complete from slave mux
//  HTRANS      in   TRANS_BITS   muxed HTRANS of current address-phase owner
//  HGRANT_M1   out  1            grant to master 1 (registered)
//  HGRANT_M2   out  1            grant to master 2 (registered)
//  HMASTER     out  MASTER_BITS  address-phase owner ID: 0, 1 or 2 (registered)
//  HMASTLOCK   out  1            current owner is performing a locked sequence (registered)
// BEHAVIOUR
//  Reset: HGRANT_M1=0, HGRANT_M2=0, HMASTER=0, HMASTLOCK=0, tenure=0.
//   The round-robin pointer gives M1 priority first. The FSM is in NONE.
//  State advances only on a rising edge with HREADY=1; with HREADY=0 all state and outputs hold.
//  FSM states:
//   - NONE: no grant.
//   - OWN: grant held, unlocked.
//   - LOCK: grant held, locked.
//  Arbitration ("re-arb") is allowed in these conditions:
//   - the FSM is in NONE;
//   - or the FSM is in OWN and the granted master's HBUSREQ=0;
//   - or the FSM is in OWN, tenure>=MAX_TENURE, the other master requests, and HTRANS is IDLE or NONSEQ.
//     This condition never breaks a burst mid-SEQ/BUSY.
//  Re-arb decision:
//   - No requests: NONE, both grants 0.
//   - One request: grant that master.
//   - Both requesting: grant the master not most recently granted. Pointer updates on each new grant.
//   - Next state is LOCK if the winner's HLOCK=1, else OWN.
//  LOCK: the grant holds regardless of tenure or the other master's request.
//   - It returns to re-arb on the edge where the granted master has HLOCK=0 and HTRANS=IDLE.
//  Pipeline (AHB ownership rule), on each HREADY=1 edge:
//   - HMASTER <= ID of the master whose HGRANT was 1 before the edge (0 if none).
//   - HMASTLOCK <= that master's HLOCK.
//   - Latency: request edge -> HGRANT after 1 HREADY edge -> HMASTER after 2.
//  Grant outputs are one-hot or zero, never both 1.
//  Tenure counter (width clog2(MAX_TENURE)+1, saturating at MAX_TENURE):
//   - +1 on each HREADY=1 edge where HTRANS is NONSEQ or SEQ and HMASTER!=0.
//   - Cleared when the grant changes or the FSM enters NONE.
//  Simultaneous events:
//   - A request drop and the other master's request on the same edge -> hand-over on that edge.
//   - Lock request and tenure expiry together -> tenure is ignored when the winner locks.
//  Reset mid-transfer: immediate return to reset values. Masters must restart their transfers.
// TESTING
//  1 Reset, no requests, HREADY=1 for 5 cycles -> HGRANT_M1=HGRANT_M2=0, HMASTER=0, HMASTLOCK=0.
//  2 HBUSREQ_M1=1 at edge 0 -> HGRANT_M1=1 after edge 1, HMASTER=1 after edge 2; drop at edge 5 -> HGRANT_M1=0 after 6, HMASTER=0 after 7.
//  3 Both request from reset -> M1 granted first; M1 drops -> M2 granted next edge; both request again after M2 drops -> M1.
//  4 M1 holds request with 8 NONSEQ/SEQ beats, M2 requesting -> rotation only on an edge with HTRANS=NONSEQ/IDLE, never on SEQ; HGRANT_M2=1 then.
//  5 M1 with HLOCK_M1=1 and M2 requesting for 20 beats -> HMASTLOCK=1, M1 keeps grant; HLOCK_M1=0 with HTRANS=IDLE -> M2 granted next edge.
//  6 HREADY=0 for 4 cycles during a hand-over -> HGRANT/HMASTER frozen; HRESET pulsed mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ahb_rr_arbiter_if.sv
// Request/grant bundle between two AHB-Lite masters and the bus arbiter.
// The slave modport is the arbiter side; the master modport is the requesting side.
interface ahb_rr_arbiter_if #(
   parameter int MASTER_BITS = 4,
   parameter int TRANS_BITS  = 2
);
   logic                   HBUSREQ_M1;
   logic                   HBUSREQ_M2;
   logic                   HLOCK_M1;
   logic                   HLOCK_M2;
   logic                   HREADY;
   logic [TRANS_BITS-1:0]  HTRANS;
   logic                   HGRANT_M1;
   logic                   HGRANT_M2;
   logic [MASTER_BITS-1:0] HMASTER;
   logic                   HMASTLOCK;

   modport slave (
      input  HBUSREQ_M1, HBUSREQ_M2,
      input  HLOCK_M1, HLOCK_M2,
      input  HREADY, HTRANS,
      output HGRANT_M1, HGRANT_M2,
      output HMASTER, HMASTLOCK
   );

   modport master (
      output HBUSREQ_M1, HBUSREQ_M2,
      output HLOCK_M1, HLOCK_M2,
      output HREADY, HTRANS,
      input  HGRANT_M1, HGRANT_M2,
      input  HMASTER, HMASTLOCK
   );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Two-master AHB-Lite round-robin arbiter with bus locking and a tenure limit.
// Grants, HMASTER and HMASTLOCK are registered and advance only when HREADY=1.
module ahb_rr_arbiter #(
   parameter int MASTER_BITS = 4,
   parameter int TRANS_BITS  = 2,
   parameter int MAX_TENURE  = 8
) (
   input logic           HCLK,
   input logic           HRESET,
   ahb_rr_arbiter_if.slave bus
);
   localparam int TW = $clog2(MAX_TENURE) + 1;

   localparam logic [1:0] S_NONE = 2'd0;
   localparam logic [1:0] S_OWN  = 2'd1;
   localparam logic [1:0] S_LOCK = 2'd2;

   localparam logic [TRANS_BITS-1:0] T_IDLE   = '0;
   localparam logic [TRANS_BITS-1:0] T_NONSEQ = TRANS_BITS'(2);
   localparam logic [TRANS_BITS-1:0] T_SEQ    = TRANS_BITS'(3);

   logic [1:0]    state, state_nx;
   logic          g1, g2, g1_nx, g2_nx;
   logic          last_m2, last_m2_nx;
   logic [TW-1:0] tenure, tenure_nx;

   logic own_req, oth_req, own_lock;
   logic idle, nonseq, beat, expired;
   logic rearb, win1, win2;

   always_comb begin
      own_req  = g1 ? bus.HBUSREQ_M1 : bus.HBUSREQ_M2;
      oth_req  = g1 ? bus.HBUSREQ_M2 : bus.HBUSREQ_M1;
      own_lock = g1 ? bus.HLOCK_M1 : bus.HLOCK_M2;
      idle     = (bus.HTRANS == T_IDLE);
      nonseq   = (bus.HTRANS == T_NONSEQ);
      beat     = nonseq || (bus.HTRANS == T_SEQ);
      expired  = (tenure >= TW'(MAX_TENURE));

      // Tenure expiry only rotates on a burst boundary
      unique case (state)
         S_NONE:  rearb = 1'b1;
         S_OWN:   rearb = !own_req ||
                          (expired && oth_req &&
                           (idle || nonseq));
         S_LOCK:  rearb = !own_lock && idle;
         default: rearb = 1'b1;
      endcase

      // last_m2 set means M2 was granted most recently
      win1 = bus.HBUSREQ_M1 &&
             (!bus.HBUSREQ_M2 || last_m2);
      win2 = bus.HBUSREQ_M2 &&
             (!bus.HBUSREQ_M1 || !last_m2);

      state_nx   = state;
      g1_nx      = g1;
      g2_nx      = g2;
      last_m2_nx = last_m2;

      if (rearb) begin
         g1_nx = win1;
         g2_nx = win2;
         unique case (1'b1)
            win1: begin
               last_m2_nx = 1'b0;
               state_nx   = bus.HLOCK_M1 ? S_LOCK : S_OWN;
            end
            win2: begin
               last_m2_nx = 1'b1;
               state_nx   = bus.HLOCK_M2 ? S_LOCK : S_OWN;
            end
            default: state_nx = S_NONE;
         endcase
      end

      tenure_nx = tenure;
      if ((g1_nx != g1) || (g2_nx != g2) ||
          (state_nx == S_NONE))
         tenure_nx = '0;
      else if (beat && (bus.HMASTER != '0) && !expired)
         tenure_nx = tenure + TW'(1);
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state         <= S_NONE;
         g1            <= 1'b0;
         g2            <= 1'b0;
         last_m2       <= 1'b1;
         tenure        <= '0;
         bus.HMASTER   <= '0;
         bus.HMASTLOCK <= 1'b0;
      end else if (bus.HREADY) begin
         state   <= state_nx;
         g1      <= g1_nx;
         g2      <= g2_nx;
         last_m2 <= last_m2_nx;
         tenure  <= tenure_nx;
         // Address-phase ownership follows the grant by one beat
         bus.HMASTER <= g1 ? MASTER_BITS'(1) :
                        g2 ? MASTER_BITS'(2) : '0;
         bus.HMASTLOCK <= (g1 && bus.HLOCK_M1) ||
                          (g2 && bus.HLOCK_M2);
      end
   end

   assign bus.HGRANT_M1 = g1;
   assign bus.HGRANT_M2 = g2;
endmodule
